r4_butterfly: RTL and testbench

R4_BUTTERFLY -- requirements
Module: r4_butterfly

---
 rtl/r4_butterfly.sv | 128 ++++++++++++
 tb/tb_r4_butterfly.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/r4_butterfly.sv
// Radix-4 DIT butterfly: two-stage pipeline (partial sums, then twiddle combine
// with (v+2)>>>2 rounding) plus a per-frame group index on the output.
module r4_butterfly #(
    parameter int DW  = 17,
    parameter int GRP = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_p_flag_in,
    input  logic [8*DW-1:0] data_in_1,
    output logic [8*DW-1:0] data_out_1,
    output logic            bfly_flag_out,
    output logic [1:0]      grp_idx,
    output logic            frame_last
);

    localparam logic [1:0]             LAST = 2'(GRP - 1);
    localparam logic signed [DW+1:0]   RND  = (DW+2)'(2);

    function automatic logic signed [DW:0] sext1(input logic [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    function automatic logic signed [DW+1:0] sext2(input logic signed [DW:0] v);
        return {v[DW], v};
    endfunction

    // Round half up by 1/4; the low DW bits are exact even at the wrap corner.
    function automatic logic [DW-1:0] rnd_scale(input logic signed [DW+1:0] v);
        logic signed [DW+1:0] sum;
        sum = v + RND;
        return DW'(sum >>> 2);
    endfunction

    logic signed [DW:0]   xr [4];
    logic signed [DW:0]   xi [4];
    logic signed [DW:0]   s_re_p1_d [4];
    logic signed [DW:0]   s_im_p1_d [4];
    logic signed [DW:0]   s_re_p1_q [4];
    logic signed [DW:0]   s_im_p1_q [4];
    logic                 vld_p1_q;

    logic signed [DW+1:0] s0r, s0i, s1r, s1i, s2r, s2i, s3r, s3i;
    logic signed [DW+1:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;
    logic [8*DW-1:0]      data_p2_d;
    logic [8*DW-1:0]      data_p2_q;
    logic                 vld_p2_q;
    logic [1:0]           grp_q;
    logic                 last_q;
    logic [1:0]           cnt_q, cnt_d;

    // Stage 1: partial sums of the even and odd input pairs
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            xr[k] = sext1(data_in_1[2*DW*k + DW +: DW]);
            xi[k] = sext1(data_in_1[2*DW*k +: DW]);
        end
        s_re_p1_d[0] = xr[0] + xr[2];
        s_im_p1_d[0] = xi[0] + xi[2];
        s_re_p1_d[1] = xr[0] - xr[2];
        s_im_p1_d[1] = xi[0] - xi[2];
        s_re_p1_d[2] = xr[1] + xr[3];
        s_im_p1_d[2] = xi[1] + xi[3];
        s_re_p1_d[3] = xr[1] - xr[3];
        s_im_p1_d[3] = xi[1] - xi[3];
    end

    // Stage 2: combine with the -j / +j rotations, then scale by 1/4
    always_comb begin
        s0r = sext2(s_re_p1_q[0]);
        s0i = sext2(s_im_p1_q[0]);
        s1r = sext2(s_re_p1_q[1]);
        s1i = sext2(s_im_p1_q[1]);
        s2r = sext2(s_re_p1_q[2]);
        s2i = sext2(s_im_p1_q[2]);
        s3r = sext2(s_re_p1_q[3]);
        s3i = sext2(s_im_p1_q[3]);
        x0r = s0r + s2r;
        x0i = s0i + s2i;
        x2r = s0r - s2r;
        x2i = s0i - s2i;
        x1r = s1r + s3i;
        x1i = s1i - s3r;
        x3r = s1r - s3i;
        x3i = s1i + s3r;
        data_p2_d = {rnd_scale(x3r), rnd_scale(x3i), rnd_scale(x2r), rnd_scale(x2i),
                     rnd_scale(x1r), rnd_scale(x1i), rnd_scale(x0r), rnd_scale(x0i)};
        cnt_d = (cnt_q == LAST) ? 2'd0 : cnt_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                s_re_p1_q[k] <= '0;
                s_im_p1_q[k] <= '0;
            end
            vld_p1_q  <= 1'b0;
            data_p2_q <= '0;
            vld_p2_q  <= 1'b0;
            grp_q     <= 2'd0;
            last_q    <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            vld_p1_q <= s_p_flag_in;
            if (s_p_flag_in) begin
                for (int k = 0; k < 4; k++) begin
                    s_re_p1_q[k] <= s_re_p1_d[k];
                    s_im_p1_q[k] <= s_im_p1_d[k];
                end
            end
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= data_p2_d;
                grp_q     <= cnt_q;
                last_q    <= (cnt_q == LAST);
                cnt_q     <= cnt_d;
            end else begin
                last_q    <= 1'b0;
            end
        end
    end

    assign data_out_1    = data_p2_q;
    assign bfly_flag_out = vld_p2_q;
    assign grp_idx       = grp_q;
    assign frame_last    = last_q;

endmodule

// File: tb/tb_r4_butterfly.sv
// Scoreboard bench for r4_butterfly: a 4-point DFT reference with 1/4 rounding
// predicts every output; a negedge monitor pops and compares.
module tb_r4_butterfly;

    localparam int DW  = 17;
    localparam int GRP = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_p_flag_in;
    logic [8*DW-1:0] data_in_1;
    logic [8*DW-1:0] data_out_1;
    logic            bfly_flag_out;
    logic [1:0]      grp_idx;
    logic            frame_last;

    r4_butterfly #(.DW(DW), .GRP(GRP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_p_flag_in   (s_p_flag_in),
        .data_in_1     (data_in_1),
        .data_out_1    (data_out_1),
        .bfly_flag_out (bfly_flag_out),
        .grp_idx       (grp_idx),
        .frame_last    (frame_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*DW-1:0] d;
        logic [1:0]      g;
        logic            l;
    } exp_t;

    exp_t            sb[$];
    int              checks   = 0;
    int              failures = 0;
    int              tb_cnt   = 0;
    logic [8*DW-1:0] hold_exp = '0;

    // Reference: X[k] = sum_n x[n] * (-j)^(n*k), then floor((X+2)/4) kept to DW bits.
    function automatic logic [8*DW-1:0] ref_bfly(input logic [8*DW-1:0] din);
        int xr[4], xi[4];
        int ar, ai, r, i;
        logic signed [DW-1:0] t;
        logic [8*DW-1:0] res;
        res = '0;
        for (int n = 0; n < 4; n++) begin
            t = din[2*DW*n + DW +: DW]; xr[n] = t;
            t = din[2*DW*n +: DW];      xi[n] = t;
        end
        for (int k = 0; k < 4; k++) begin
            ar = 0; ai = 0;
            for (int n = 0; n < 4; n++) begin
                case ((n * k) % 4)
                    0: begin ar += xr[n]; ai += xi[n]; end
                    1: begin ar += xi[n]; ai -= xr[n]; end
                    2: begin ar -= xr[n]; ai -= xi[n]; end
                    default: begin ar -= xi[n]; ai += xr[n]; end
                endcase
            end
            r = (ar + 2) >>> 2;
            i = (ai + 2) >>> 2;
            res[2*DW*k + DW +: DW] = r[DW-1:0];
            res[2*DW*k +: DW]      = i[DW-1:0];
        end
        return res;
    endfunction

    function automatic logic [2*DW-1:0] pk(input int re, input int im);
        logic [31:0] a, b;
        a = re; b = im;
        return {a[DW-1:0], b[DW-1:0]};
    endfunction

    function automatic logic [DW-1:0] rnd_comp();
        logic [DW-1:0] v;
        case ($urandom_range(0, 3))
            0:       begin v = '0; v[DW-1] = 1'b1; end
            1:       begin v = '1; v[DW-1] = 1'b0; end
            default: v = DW'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [8*DW-1:0] rnd_group();
        logic [8*DW-1:0] d;
        for (int c = 0; c < 8; c++) d[c*DW +: DW] = rnd_comp();
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [8*DW-1:0] e);
        exp_t x;
        x.d = e;
        x.g = 2'(tb_cnt);
        x.l = (tb_cnt == GRP - 1);
        sb.push_back(x);
        tb_cnt = (tb_cnt + 1) % GRP;
    endtask

    task automatic send(input logic [8*DW-1:0] d, input logic [8*DW-1:0] e);
        data_in_1   = d;
        s_p_flag_in = 1'b1;
        push_exp(e);
        tick();
        s_p_flag_in = 1'b0;
        data_in_1   = rnd_group();
    endtask

    task automatic chk(input string name, input logic [8*DW-1:0] act, input logic [8*DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, data_out_1, '0);
        chk({tag, "_flag"}, {{(8*DW-1){1'b0}}, bfly_flag_out}, '0);
        chk({tag, "_grp"},  {{(8*DW-2){1'b0}}, grp_idx}, '0);
        chk({tag, "_last"}, {{(8*DW-1){1'b0}}, frame_last}, '0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            hold_exp = '0;
        end else if (bfly_flag_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_output: got flag=1 grp=%0d expected no output", grp_idx);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("out_data", data_out_1, x.d);
                chk("out_grp",  {{(8*DW-2){1'b0}}, grp_idx}, {{(8*DW-2){1'b0}}, x.g});
                chk("out_last", {{(8*DW-1){1'b0}}, frame_last}, {{(8*DW-1){1'b0}}, x.l});
                hold_exp = x.d;
            end
        end else begin
            chk("hold_data", data_out_1, hold_exp);
            chk("idle_last", {{(8*DW-1){1'b0}}, frame_last}, '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n       = 1'b1;
        s_p_flag_in = 1'b0;
        data_in_1   = '0;
        repeat (3) tick();
        chk_zero("reset_state");
        rst_n = 1'b0;
        tick();

        // Directed groups with hand-derived results
        send({pk(0, 0), pk(0, 0), pk(0, 0), pk(100, 0)},
             {pk(25, 0), pk(25, 0), pk(25, 0), pk(25, 0)});
        send({pk(65535, -65536), pk(65535, -65536), pk(65535, -65536), pk(65535, -65536)},
             {pk(0, 0), pk(0, 0), pk(0, 0), pk(65535, -65536)});
        send({pk(0, 0), pk(0, 0), pk(4, 0), pk(0, 0)},
             {pk(0, 1), pk(-1, 0), pk(0, -1), pk(1, 0)});
        repeat (4) tick();

        // Flags during reset are ignored; counter restarts at 0
        rst_n       = 1'b1;
        s_p_flag_in = 1'b1;
        data_in_1   = rnd_group();
        repeat (2) tick();
        s_p_flag_in = 1'b0;
        chk_zero("reset_ignore");
        rst_n  = 1'b0;
        tb_cnt = 0;
        tick();

        // Eight back-to-back groups: grp 0..3 twice, frame_last on 4th and 8th
        for (int n = 0; n < 8; n++) begin
            logic [8*DW-1:0] d;
            d = rnd_group();
            send(d, ref_bfly(d));
        end
        repeat (4) tick();

        // In-flight group killed by reset one cycle after its pulse
        data_in_1   = rnd_group();
        s_p_flag_in = 1'b1;
        tick();
        s_p_flag_in = 1'b0;
        rst_n       = 1'b1;
        tick();
        chk_zero("reset_midflight");
        rst_n  = 1'b0;
        tb_cnt = 0;
        repeat (5) tick();

        // Random groups with random gaps
        for (int n = 0; n < 40; n++) begin
            logic [8*DW-1:0] d;
            d = rnd_group();
            send(d, ref_bfly(d));
            repeat ($urandom_range(0, 15)) tick();
        end

        w = 0;
        while (sb.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending outputs expected 0", sb.size());
        end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
